// File: rtl/ling_adder_pkg.sv
// ----------------------------------------------------------------------------
// ling_adder_pkg
// Shared constants, helpers and types for the pipelined Ling adder.
//   GROUP_W      : bits per Ling group (16)
//   MAX_WIDTH    : widest supported operand (128)
//   group_count  : number of 16-bit groups for a given operand width
//   stage_rec_t  : first pipeline stage record (valid, t=a|b, p=a^b, g=a&b, cin),
//                  sized for MAX_WIDTH; narrower adders use the low bits.
// ----------------------------------------------------------------------------
package ling_adder_pkg;

    localparam int GROUP_W   = 16;
    localparam int MAX_WIDTH = 128;

    function automatic int group_count(input int width);
        return width / GROUP_W;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [MAX_WIDTH-1:0] t;
        logic [MAX_WIDTH-1:0] p;
        logic [MAX_WIDTH-1:0] g;
        logic                 cin;
    } stage_rec_t;

endpackage

// File: rtl/ling_adder_pipe_group16.sv
// ----------------------------------------------------------------------------
// ling_group16
// Combinational 16-bit Ling group.
//   t  [15:0] : bit transmit (a|b), or group-level transmit at the upper level
//   g  [15:0] : bit generate (a&b), or group-level generate
//   ci        : group carry-in
//   h  [16:1] : Ling pseudo-carries; the real carry into bit k is t[k-1] & h[k]
//   gp        : group propagate (all bits transmit)
//   gg        : group carry-out for the given ci
// ----------------------------------------------------------------------------
module ling_group16
    import ling_adder_pkg::*;
(
    input  logic [GROUP_W-1:0] t,
    input  logic [GROUP_W-1:0] g,
    input  logic               ci,
    output logic [GROUP_W:1]   h,
    output logic               gp,
    output logic               gg
);

    // h[k+1] = g[k] | c[k] and c[k] = t[k-1] & h[k], so the recurrence only
    // needs t of the previous bit; this is what shortens the carry path.
    always_comb begin
        h    = '0;
        h[1] = g[0] | ci;
        for (int k = 1; k < GROUP_W; k++) begin
            h[k+1] = g[k] | (t[k-1] & h[k]);
        end
    end

    assign gp = &t;
    assign gg = t[GROUP_W-1] & h[GROUP_W];

endmodule

// File: rtl/ling_adder_pipe.sv
// ----------------------------------------------------------------------------
// ling_adder_pipe
// Three-stage pipelined Ling carry-lookahead adder with valid/ready handshake.
//   {cout, sum} = a + b' + cin', ovf = signed overflow of that sum.
// Optional feature macro: LING_ADDER_SUB_EN adds the `sub` port; with sub=1,
// b' = ~b and cin' = ~cin (subtract / subtract-with-borrow).
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand beat handshake (a, b, cin [, sub])
//   out_valid / out_ready : result beat handshake (sum, cout, ovf)
// Stages: S1 bit t/p/g, S2 per-group Ling h and group P/G (group carry-in 0),
//         S3 group lookahead, carry correction, sum/cout/ovf.
// ----------------------------------------------------------------------------
module ling_adder_pipe
    import ling_adder_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int GROUP = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef LING_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = group_count(WIDTH);

    generate
        if ((WIDTH % GROUP_W) != 0 || WIDTH < GROUP_W || WIDTH > MAX_WIDTH || GROUP != GROUP_W) begin : g_bad_cfg
            $error("ling_adder_pipe: WIDTH must be a multiple of 16 in 16..128 and GROUP must be 16");
        end
    endgenerate

    // ---------------- effective operands ----------------
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
`ifdef LING_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = cin ^ sub;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // ---------------- flow control ----------------
    stage_rec_t             s1_reg;
    stage_rec_t             s1_next;
    logic                   v2_reg;
    logic [WIDTH-1:0]       t2_reg;
    logic [WIDTH-1:0]       p2_reg;
    logic [NG-1:0][16:1]    h2_reg;
    logic [NG-1:0]          gp2_reg;
    logic [NG-1:0]          gg2_reg;
    logic                   cin2_reg;
    logic                   out_valid_reg;
    logic [WIDTH-1:0]       sum_reg;
    logic                   cout_reg;
    logic                   ovf_reg;

    logic ready1;
    logic ready2;
    logic ready3;

    // Each stage may load when empty or when its occupant leaves this cycle.
    assign ready3   = ~out_valid_reg | out_ready;
    assign ready2   = ~v2_reg | ready3;
    assign ready1   = ~s1_reg.valid | ready2;
    assign in_ready = ready1 & ~rst;

    // ---------------- S1 ----------------
    always_comb begin
        s1_next               = '0;
        s1_next.valid         = 1'b1;
        s1_next.t[WIDTH-1:0]  = a | b_eff;
        s1_next.p[WIDTH-1:0]  = a ^ b_eff;
        s1_next.g[WIDTH-1:0]  = a & b_eff;
        s1_next.cin           = cin_eff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg <= '0;
        end else if (ready1) begin
            if (in_valid) begin
                s1_reg <= s1_next;
            end else begin
                s1_reg.valid <= 1'b0;
            end
        end
    end

    generate
        if (WIDTH < MAX_WIDTH) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^{s1_reg.t[MAX_WIDTH-1:WIDTH], s1_reg.p[MAX_WIDTH-1:WIDTH],
                                  s1_reg.g[MAX_WIDTH-1:WIDTH]};
        end
    endgenerate

    // ---------------- S2 ----------------
    // Groups are evaluated with carry-in 0; the real carry-in is folded in at S3.
    logic [NG-1:0][16:1] h_s2;
    logic [NG-1:0]       gp_s2;
    logic [NG-1:0]       gg_s2;

    generate
        for (genvar gi = 0; gi < NG; gi++) begin : g_grp
            ling_group16 u_grp (
                .t  (s1_reg.t[GROUP_W*gi +: GROUP_W]),
                .g  (s1_reg.g[GROUP_W*gi +: GROUP_W]),
                .ci (1'b0),
                .h  (h_s2[gi]),
                .gp (gp_s2[gi]),
                .gg (gg_s2[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_reg   <= 1'b0;
            t2_reg   <= '0;
            p2_reg   <= '0;
            h2_reg   <= '0;
            gp2_reg  <= '0;
            gg2_reg  <= '0;
            cin2_reg <= 1'b0;
        end else if (ready2) begin
            v2_reg <= s1_reg.valid;
            if (s1_reg.valid) begin
                t2_reg   <= s1_reg.t[WIDTH-1:0];
                p2_reg   <= s1_reg.p[WIDTH-1:0];
                h2_reg   <= h_s2;
                gp2_reg  <= gp_s2;
                gg2_reg  <= gg_s2;
                cin2_reg <= s1_reg.cin;
            end
        end
    end

    // ---------------- S3: group lookahead ----------------
    logic [NG-1:0] grp_cin;

    generate
        if (NG > 1) begin : g_la
            // Group generate implies nothing about group propagate, so the
            // group-level transmit is G|P; that keeps C = T & H valid.
            logic [GROUP_W-1:0] la_t;
            logic [GROUP_W-1:0] la_g;
            logic [GROUP_W:1]   la_h;
            logic               la_gp;
            logic               la_gg;
            logic               unused_la;

            always_comb begin
                la_t         = '0;
                la_g         = '0;
                la_t[NG-1:0] = gg2_reg | gp2_reg;
                la_g[NG-1:0] = gg2_reg;
            end

            ling_group16 u_la (
                .t  (la_t),
                .g  (la_g),
                .ci (cin2_reg),
                .h  (la_h),
                .gp (la_gp),
                .gg (la_gg)
            );

            assign grp_cin[0] = cin2_reg;
            for (genvar gi = 1; gi < NG; gi++) begin : g_gc
                assign grp_cin[gi] = la_t[gi-1] & la_h[gi];
            end
            assign unused_la = ^{la_h[GROUP_W:NG], la_gp, la_gg};
        end else begin : g_one
            logic unused_one;
            assign grp_cin[0] = cin2_reg;
            assign unused_one = ^{gg2_reg, gp2_reg};
        end
    endgenerate

    // ---------------- S3: bit carries, sum ----------------
    // True pseudo-carry with group carry-in ci is h0[k] | ci & (t of all lower
    // bits in the group); the real carry is then t[k-1] & h[k].
    logic [WIDTH:0]   carry;
    logic             run;
    logic [WIDTH-1:0] sum_next;
    logic             cout_next;
    logic             ovf_next;

    always_comb begin
        carry    = '0;
        run      = 1'b1;
        carry[0] = cin2_reg;
        for (int j = 0; j < NG; j++) begin
            run = 1'b1;
            for (int k = 1; k <= GROUP_W; k++) begin
                carry[GROUP_W*j+k] = t2_reg[GROUP_W*j+k-1] & (h2_reg[j][k] | (grp_cin[j] & run));
                run                = run & t2_reg[GROUP_W*j+k-1];
            end
        end
    end

    assign sum_next  = p2_reg ^ carry[WIDTH-1:0];
    assign cout_next = carry[WIDTH];
    // Signed overflow is exactly a disagreement between carry into and out of the MSB.
    assign ovf_next  = carry[WIDTH] ^ carry[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else if (ready3) begin
            out_valid_reg <= v2_reg;
            if (v2_reg) begin
                sum_reg  <= sum_next;
                cout_reg <= cout_next;
                ovf_reg  <= ovf_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_ling_adder_pipe.sv
module tb_ling_adder_pipe;

    localparam int W = 64;
    typedef logic [W+1:0] val_t;   // {ovf, cout, sum}

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_v;
    logic [W-1:0] b_v;
    logic         cin_v;
    logic         sub_v;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    ling_adder_pipe #(.WIDTH(W), .GROUP(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_v),
        .b         (b_v),
        .cin       (cin_v),
`ifdef LING_ADDER_SUB_EN
        .sub       (sub_v),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    int   n_total = 0;
    int   n_pass  = 0;
    int   n_emit  = 0;
    val_t exp_q[$];

    logic         acc_s, emt_s, ov_s, ir_s, cout_s, ovf_s;
    logic [W-1:0] sum_s;
    logic         hold_pending = 1'b0;
    val_t         held;

    // Reference: plain wide arithmetic on the effective operands.
    function automatic val_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic cv, input logic sv);
        logic [W-1:0] be;
        logic         ce;
        logic [W:0]   r;
        logic         ov;
        be = sv ? ~bv : bv;
        ce = cv ^ sv;
        r  = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, ce};
        ov = (av[W-1] == be[W-1]) && (r[W-1] != av[W-1]);
        return {ov, r};
    endfunction

    task automatic chk(input string tag, input val_t obs, input val_t expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    endtask

    // One clock cycle: called at a falling edge with inputs already driven.
    task automatic step();
        #1;
        ir_s   = in_ready;
        ov_s   = out_valid;
        sum_s  = sum;
        cout_s = cout;
        ovf_s  = ovf;
        acc_s  = in_valid & in_ready;
        emt_s  = out_valid & out_ready;
        if (hold_pending) begin
            chk("hold_valid", val_t'(ov_s), 1);
            chk("hold_data", {ovf_s, cout_s, sum_s}, held);
        end
        hold_pending = ov_s && !out_ready && !rst;
        held         = {ovf_s, cout_s, sum_s};
        if (emt_s === 1'b1) begin
            n_total++;
            assert (exp_q.size() != 0) n_pass++;
            else $error("FAIL spurious_beat observed=sum 0x%0h expected=no beat", sum_s);
            if (exp_q.size() != 0) begin
                chk("stream_result", {ovf_s, cout_s, sum_s}, exp_q.pop_front());
            end
            $display("beat %0d: sum=%h cout=%b ovf=%b", n_emit, sum_s, cout_s, ovf_s);
            n_emit++;
        end
        if (acc_s === 1'b1) exp_q.push_back(model(a_v, b_v, cin_v, sub_v));
        @(negedge clk);
    endtask

    // Single beat through an empty pipe: latency and result checked.
    task automatic single(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic sv, input val_t expv);
        a_v = av; b_v = bv; cin_v = cv; sub_v = sv;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        chk({tag, "_accept"}, val_t'(acc_s), 1);
        in_valid = 1'b0;
        step();
        chk({tag, "_lat1"}, val_t'(ov_s), 0);
        step();
        chk({tag, "_lat2"}, val_t'(ov_s), 0);
        step();
        chk({tag, "_lat3"}, val_t'(ov_s), 1);
        chk({tag, "_result"}, {ovf_s, cout_s, sum_s}, expv);
        step();
    endtask

    initial begin
        int sent;
        int cyc;
        int cnt;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_v = '0; b_v = '0; cin_v = 1'b0; sub_v = 1'b0;

        // Reset state
        @(negedge clk);
        step();
        step();
        chk("rst_in_ready", val_t'(ir_s), 0);
        chk("rst_out_valid", val_t'(ov_s), 0);
        chk("rst_outputs", {ovf_s, cout_s, sum_s}, 0);
        rst = 1'b0;
        step();
        chk("release_in_ready", val_t'(ir_s), 1);

        // Directed carry / overflow boundaries
        single("all_ones_plus_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
               {1'b0, 1'b1, 64'h0});
        single("max_pos_plus_one", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
               {1'b1, 1'b0, 64'h8000_0000_0000_0000});
`ifdef LING_ADDER_SUB_EN
        single("sub_5_minus_7", 64'h5, 64'h7, 1'b0, 1'b1,
               {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
        single("sub_min_minus_1", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
               {1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF});
        single("sub_borrow_in", 64'h9, 64'h4, 1'b1, 1'b1,
               {1'b0, 1'b1, 64'h4});
`endif

        // Random stream with random backpressure
        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < 20000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            a_v = {$urandom, $urandom};
            b_v = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b_v = ~a_v;                              // full propagate chain
                1: a_v = 64'hFFFF_FFFF_FFFF_FFFF;
                2: b_v = b_v & {2{32'h0000_FFFF}};
                default: ;
            endcase
            cin_v = 1'($urandom_range(0, 1));
`ifdef LING_ADDER_SUB_EN
            sub_v = 1'($urandom_range(0, 1));
`endif
            out_ready = 1'($urandom_range(0, 1));
            step();
            if (acc_s) sent++;
            cyc++;
        end
        chk("random_sent", val_t'(sent), 1000);
        in_valid = 1'b0; out_ready = 1'b1; sub_v = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("random_drain_empty", val_t'(exp_q.size()), 0);

        // Fill with out_ready low, then full-rate flow
        in_valid = 1'b1; out_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            a_v = {$urandom, $urandom}; b_v = {$urandom, $urandom}; cin_v = 1'($urandom_range(0, 1));
            step();
            if (acc_s) cnt++;
        end
        chk("bp_accepts", val_t'(cnt), 3);
        chk("bp_in_ready_low", val_t'(ir_s), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_v = {$urandom, $urandom}; b_v = {$urandom, $urandom}; cin_v = 1'($urandom_range(0, 1));
            step();
            chk("thru_accept", val_t'(acc_s), 1);
            chk("thru_emit", val_t'(emt_s), 1);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("thru_drain_empty", val_t'(exp_q.size()), 0);

        // Reset with three beats in flight
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_v = {$urandom, $urandom}; b_v = {$urandom, $urandom};
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        exp_q.delete();
        rst = 1'b0;
        step();
        chk("midrst_out_valid", val_t'(ov_s), 0);
        chk("midrst_outputs", {ovf_s, cout_s, sum_s}, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("midrst_no_stale", val_t'(ov_s), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
